ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000; clk cycles the bus clock is held low before a request (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000; max clk cycles between consecutive device clock falling edges, and from request to first falling edge (20 ms at 100 MHz).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 tx_data  input  8  command byte to send to the keyboard.
REQ-007 tx_valid  input  1  command byte present.
REQ-008 tx_ready  output  1  block idle, accepts a byte.
REQ-009 ps2_clk_in  input  1  sampled level of the PS/2 clock line (asynchronous).
REQ-010 ps2_clk_oe  output  1  1 = pull PS/2 clock line low, 0 = release.
REQ-011 ps2_data_in  input  1  sampled level of the PS/2 data line (asynchronous).
REQ-012 ps2_data_oe  output  1  1 = pull PS/2 data line low, 0 = release.
REQ-013 done  output  1  one-cycle pulse: frame sent successfully.
REQ-014 err  output  1  one-cycle pulse: frame aborted (timeout or missing ack).

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL pass through 2-flop synchronizers; a falling edge is synchronized-clock 1 then 0 on consecutive clk cycles.
REQ-016 Handshake: byte accepted on the cycle tx_valid && tx_ready; tx_data latched; tx_ready deasserts the next cycle; tx_valid while busy is ignored.
REQ-017 States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE.
REQ-018 IDLE: both oe = 0, tx_ready = 1; on accept -> INHIBIT, latch odd parity (parity = ~^tx_data).
REQ-019 INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then ps2_data_oe = 1 (start bit) -> REQUEST.
REQ-020 REQUEST: ps2_clk_oe = 0 one cycle after entry, ps2_data_oe stays 1; wait for first falling edge -> SHIFT.
REQ-021 SHIFT: on falling edges 1..8 drive data bit 0..7 LSB first, 9th parity, 10th stop (ps2_data_oe = 0); data_oe = ~bit, updated the cycle after the edge; after the 10th edge -> ACK.
REQ-022 ACK: on the 11th falling edge sample synchronized data; -> RELEASE.
REQ-023 RELEASE: wait until synchronized clock and data both 1, then pulse done (or err per REQ-027) -> IDLE.
REQ-024 Watchdog counter reset on every falling edge and on entry to REQUEST; reaching TIMEOUT_CYCLES in REQUEST/SHIFT/ACK/RELEASE: both oe = 0 same cycle, err pulse, -> IDLE.
REQ-025 done and err SHALL never assert in the same cycle; ps2_clk_oe SHALL never be 1 outside INHIBIT and first REQUEST cycle.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) force: state IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, done = 0, err = 0, counters 0; tx_ready = 1 after release; mid-frame reset releases the bus with no pulse.

Configuration
REQ-027 Macro PS2_TX_ACK_CHECK_EN: defined -> ack sampled high in ACK ends with err instead of done; undefined -> ack level ignored, frame always ends with done (timeouts still give err).

Verification
REQ-028 tx_data=0xED, device model clocks 11 edges, acks low -> data_oe after edges 1..10 = 0,1,0,0,1,0,0,0,0,0 (bits 1,0,1,1,0,1,1,1, parity 1, stop); done pulse once; tx_ready back to 1.
REQ-029 tx_data=0xF4 -> parity bit 0 (data_oe=1 after edge 9); ps2_clk_oe high exactly INHIBIT_CYCLES cycles before data_oe rises.
REQ-030 Request issued, device never clocks -> err pulse TIMEOUT_CYCLES after REQUEST entry; both oe = 0; IDLE.
REQ-031 Device leaves data high at edge 11 -> err with PS2_TX_ACK_CHECK_EN, done without.
REQ-032 rst_n asserted after 5th edge -> both oe = 0 immediately, no done/err; next byte 0x00 sends normally (parity 1).
REQ-033 tx_valid held with new byte 0xFF during a 0xED frame -> ignored; 0xFF accepted only after done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ack, release.
// Optional macro PS2_TX_ACK_CHECK_EN turns a missing device ack into an err pulse instead of done.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_oe,
  input  logic       ps2_data_in,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQUEST = 3'd2,
    S_SHIFT   = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic          tx_ready_q, tx_ready_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef PS2_TX_ACK_CHECK_EN
  logic          nack_q, nack_d;
`endif
  logic          fall_s;

  assign fall_s = clk_prev_q & ~clk_sync_q[1];

  // Next-state and next-output logic; the frame shifter holds {stop, parity, data} LSB first.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    tx_ready_d  = tx_ready_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_sync_q[1];
`ifdef PS2_TX_ACK_CHECK_EN
    nack_d      = nack_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        cnt_d      = '0;
        idx_d      = 4'd0;
        if (tx_valid && tx_ready_q) begin
          shift_d    = {1'b1, odd_parity(tx_data), tx_data};
          tx_ready_d = 1'b0;
          clk_oe_d   = 1'b1;
          state_d    = S_INHIBIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQUEST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_REQUEST, S_SHIFT, S_ACK: begin
        if (state_q == S_REQUEST) begin
          clk_oe_d = 1'b0;
        end else begin
          clk_oe_d = clk_oe_q;
        end
        if (fall_s) begin
          cnt_d = '0;
          if (state_q == S_ACK) begin
`ifdef PS2_TX_ACK_CHECK_EN
            nack_d = data_sync_q[1];
`endif
            state_d = S_RELEASE;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[9:1]};
            idx_d     = idx_q + 4'd1;
            if (idx_q == 4'd9) begin
              state_d = S_ACK;
            end else begin
              state_d = S_SHIFT;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          err_d      = 1'b1;
          tx_ready_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (clk_sync_q[1] && data_sync_q[1]) begin
`ifdef PS2_TX_ACK_CHECK_EN
          done_d = ~nack_q;
          err_d  = nack_q;
`else
          done_d = 1'b1;
`endif
          tx_ready_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          err_d      = 1'b1;
          tx_ready_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        tx_ready_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= 10'd0;
      idx_q       <= 4'd0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      tx_ready_q  <= 1'b1;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      tx_ready_q  <= tx_ready_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PS2_TX_ACK_CHECK_EN
      nack_q      <= nack_d;
`endif
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 300;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, clk_oe, data_oe, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = dev_clk & ~clk_oe;
  assign ps2_data_line = dev_data & ~data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_line), .ps2_clk_oe(clk_oe), .ps2_data_in(ps2_data_line),
    .ps2_data_oe(data_oe), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, err_cnt, both_cnt, inh_cnt, ovl_cnt;
  int done_cyc, err_cyc, req_cyc, clkoe_rise_cyc;
  logic clk_oe_prev = 1'b0;

  // Bus monitor sampled on the falling clk edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (err) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
    if (done && err) both_cnt = both_cnt + 1;
    if (clk_oe && !data_oe) inh_cnt = inh_cnt + 1;
    if (clk_oe && data_oe) begin
      if (ovl_cnt == 0) req_cyc = cyc;
      ovl_cnt = ovl_cnt + 1;
    end
    if (clk_oe && !clk_oe_prev) clkoe_rise_cyc = cyc;
    clk_oe_prev = clk_oe;
  end

  task automatic clear_mon();
    done_cnt = 0; err_cnt = 0; both_cnt = 0; inh_cnt = 0; ovl_cnt = 0;
    done_cyc = 0; err_cyc = 0; req_cyc = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: data_oe the host should show after falling edge k of a frame carrying b.
  function automatic logic exp_oe(input logic [7:0] b, input int k);
    logic par;
    par = (($countones(b) % 2) == 0);
    if (k <= 8) return ~b[k-1];
    else if (k == 9) return ~par;
    else return 1'b0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 1000) begin tick(1); w++; end
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic device(input int n, input bit ack_low, output logic [11:1] oe);
    int w;
    oe = '0;
    w = 0;
    while (!(data_oe === 1'b1 && clk_oe === 1'b0) && w < 2000) begin tick(1); w++; end
    if (w >= 2000) begin
      checks++; errors++;
      $display("FAIL device_wait: data_oe=%b clk_oe=%b, expected data_oe=1 clk_oe=0", data_oe, clk_oe);
      return;
    end
    tick(4);
    for (int k = 1; k <= n; k++) begin
      dev_clk = 1'b0;
      if (k == 11 && ack_low) dev_data = 1'b0;
      tick(HALF);
      oe[k] = data_oe;
      dev_clk = 1'b1;
      tick(HALF);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_end();
    int w;
    w = 0;
    while (done_cnt + err_cnt == 0 && w < 200) begin tick(1); w++; end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL wait_end: no done/err within 200 cycles, expected one pulse");
    end
    tick(3);
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack_low, output logic [11:1] oe);
    clear_mon();
    send_byte(b);
    device(11, ack_low, oe);
    wait_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++; if (clk_oe !== 1'b0) begin errors++; $display("FAIL rst_clk_oe: got %b want 0", clk_oe); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe: got %b want 0", data_oe); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {done, err}); end
    rst_n = 1'b1;
    tick(2);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_frame_ed();
    logic [11:1] oe;
    run_frame(8'hED, 1'b1, oe);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (oe[k] !== exp_oe(8'hED, k)) begin
        errors++; $display("FAIL ed_edge%0d: data_oe=%b want %b", k, oe[k], exp_oe(8'hED, k));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ed_done: count=%0d want 1", done_cnt); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL ed_err: count=%0d want 0", err_cnt); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL ed_both: count=%0d want 0", both_cnt); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ed_tx_ready: got %b want 1", tx_ready); end
    checks++; if (inh_cnt !== INH) begin errors++; $display("FAIL ed_inhibit: cycles=%0d want %0d", inh_cnt, INH); end
    checks++; if (ovl_cnt !== 1) begin errors++; $display("FAIL ed_request_overlap: cycles=%0d want 1", ovl_cnt); end
  endtask

  task automatic test_parity_f4();
    logic [11:1] oe;
    run_frame(8'hF4, 1'b1, oe);
    checks++; if (oe[9] !== 1'b1) begin errors++; $display("FAIL f4_parity: data_oe=%b want 1", oe[9]); end
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (oe[k] !== exp_oe(8'hF4, k)) begin
        errors++; $display("FAIL f4_edge%0d: data_oe=%b want %b", k, oe[k], exp_oe(8'hF4, k));
      end
    end
    checks++; if (inh_cnt !== INH) begin errors++; $display("FAIL f4_inhibit: cycles=%0d want %0d", inh_cnt, INH); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL f4_done: count=%0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    logic [11:1] oe;
    logic [7:0]  b;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom_range(0, 255));
      run_frame(b, 1'b1, oe);
      for (int k = 1; k <= 10; k++) begin
        checks++;
        if (oe[k] !== exp_oe(b, k)) begin
          errors++; $display("FAIL rand_%02h_edge%0d: data_oe=%b want %b", b, k, oe[k], exp_oe(b, k));
        end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_%02h_done: count=%0d want 1", b, done_cnt); end
    end
  endtask

  task automatic test_timeout();
    int w;
    clear_mon();
    send_byte(8'h5A);
    w = 0;
    while (err_cnt == 0 && w < INH + TO + 100) begin tick(1); w++; end
    tick(2);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err: count=%0d want 1", err_cnt); end
    checks++; if (err_cyc - req_cyc !== TO) begin errors++; $display("FAIL to_latency: cycles=%0d want %0d", err_cyc - req_cyc, TO); end
    checks++; if ({clk_oe, data_oe} !== 2'b00) begin errors++; $display("FAIL to_oe: got %b want 00", {clk_oe, data_oe}); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL to_done: count=%0d want 0", done_cnt); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL to_tx_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_nack();
    logic [11:1] oe;
    int exp_done, exp_err;
`ifdef PS2_TX_ACK_CHECK_EN
    exp_done = 0; exp_err = 1;
`else
    exp_done = 1; exp_err = 0;
`endif
    run_frame(8'h3C, 1'b0, oe);
    checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL nack_done: count=%0d want %0d", done_cnt, exp_done); end
    checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL nack_err: count=%0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_reset_mid();
    logic [11:1] oe;
    clear_mon();
    send_byte(8'hA5);
    device(5, 1'b1, oe);
    rst_n = 1'b0;
    #1;
    checks++; if ({clk_oe, data_oe} !== 2'b00) begin errors++; $display("FAIL midrst_oe: got %b want 00", {clk_oe, data_oe}); end
    tick(3);
    rst_n = 1'b1;
    tick(30);
    checks++; if (done_cnt + err_cnt !== 0) begin errors++; $display("FAIL midrst_pulse: count=%0d want 0", done_cnt + err_cnt); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_tx_ready: got %b want 1", tx_ready); end
    run_frame(8'h00, 1'b1, oe);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (oe[k] !== exp_oe(8'h00, k)) begin
        errors++; $display("FAIL midrst_00_edge%0d: data_oe=%b want %b", k, oe[k], exp_oe(8'h00, k));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midrst_00_done: count=%0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [11:1] oe;
    int w;
    clear_mon();
    send_byte(8'hED);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    device(11, 1'b1, oe);
    w = 0;
    while (done_cnt == 0 && w < 200) begin tick(1); w++; end
    w = 0;
    while (tx_ready !== 1'b0 && w < 50) begin tick(1); w++; end
    tx_valid = 1'b0;
    tick(2);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (oe[k] !== exp_oe(8'hED, k)) begin
        errors++; $display("FAIL b2b_ed_edge%0d: data_oe=%b want %b", k, oe[k], exp_oe(8'hED, k));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_ed_done: count=%0d want 1", done_cnt); end
    checks++;
    if (!(clkoe_rise_cyc > done_cyc)) begin
      errors++; $display("FAIL b2b_accept_order: inhibit at %0d, done at %0d; want inhibit after done", clkoe_rise_cyc, done_cyc);
    end
    clear_mon();
    device(11, 1'b1, oe);
    wait_end();
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (oe[k] !== exp_oe(8'hFF, k)) begin
        errors++; $display("FAIL b2b_ff_edge%0d: data_oe=%b want %b", k, oe[k], exp_oe(8'hFF, k));
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_ff_done: count=%0d want 1", done_cnt); end
  endtask

  initial begin
    clear_mon();
    clkoe_rise_cyc = 0;
    test_reset();
    test_frame_ed();
    test_parity_f4();
    test_random();
    test_timeout();
    test_nack();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
